// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared types and constants for the register-file writeback path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package regfile_wb_arbiter_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;

    // One writeback request as seen by the register file port.
    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } wb_req_t;

    // Round-robin successor: the slot after the winner gets first look next time.
    function automatic int rr_next(input int g, input int n);
        return (g + 1 >= n) ? 0 : g + 1;
    endfunction

endpackage

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester at or after ptr_i.
// Latency: combinational, zero cycles.
// Backpressure: en_i low suppresses every grant; requesters simply wait.
module regfile_wb_arbiter_rr_arbiter #(
    parameter int N     = 3,
    parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req_i,
    input  logic [PTR_W-1:0] ptr_i,
    input  logic             en_i,
    output logic [N-1:0]     gnt_o
);

    logic found;
    int   idx;

    // Scan ptr, ptr+1, ... (mod N) and grant the first active request.
    always_comb begin
        gnt_o = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr_i) + k) % N;
            if (en_i && !found && req_i[idx]) begin
                gnt_o[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register file write port among NUM_REQ writeback sources, round-robin.
// Latency: 1 cycle from accepted request to rf_we_o/rf_waddr_o/rf_wdata_o.
// Backpressure: valid/ready per requester; stall_i or reset withholds every ready.
module regfile_wb_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int XLEN    = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    stall_i,
    input  logic [NUM_REQ-1:0]      req_valid_i,
    input  logic [NUM_REQ*5-1:0]    req_rd_i,
    input  logic [NUM_REQ*XLEN-1:0] req_data_i,
    output logic [NUM_REQ-1:0]      req_ready_o,
    output logic                    rf_we_o,
    output logic [4:0]              rf_waddr_o,
    output logic [XLEN-1:0]         rf_wdata_o,
    output logic [31:0]             wb_pending_o
);
    import regfile_wb_arbiter_pkg::*;

    localparam int PTR_W = $clog2(NUM_REQ);

    logic [PTR_W-1:0]      rr_ptr_q, rr_ptr_d;
    logic                  rf_we_q, rf_we_d;
    logic [REG_ADDR_W-1:0] rf_waddr_q, rf_waddr_d;
    logic [XLEN-1:0]       rf_wdata_q, rf_wdata_d;
    logic [NUM_REQ-1:0]    gnt;
    logic [NUM_REGS-1:0]   pending;
    logic                  arb_en;

    // Grants are withheld while the pipeline freezes the port or during reset.
    assign arb_en = !stall_i && !reset;

    regfile_wb_arbiter_rr_arbiter #(
        .N     (NUM_REQ),
        .PTR_W (PTR_W)
    ) u_arb (
        .req_i (req_valid_i),
        .ptr_i (rr_ptr_q),
        .en_i  (arb_en),
        .gnt_o (gnt)
    );

    assign req_ready_o = gnt;

    // Next state: the winner's rd/data go to the port; x0 writes are consumed silently.
    always_comb begin
        rr_ptr_d   = rr_ptr_q;
        rf_we_d    = 1'b0;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                rr_ptr_d   = PTR_W'(rr_next(i, NUM_REQ));
                rf_we_d    = (req_rd_i[5*i +: 5] != '0);
                rf_waddr_d = req_rd_i[5*i +: 5];
                rf_wdata_d = req_data_i[XLEN*i +: XLEN];
            end
        end
    end

    // Pointer and output register; reset discards any write not yet presented.
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr_q   <= '0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
        end
    end

    // Pending bitmap: every waiting destination plus the write on the port now; x0 never pends.
    always_comb begin
        pending = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_valid_i[i]) begin
                pending[req_rd_i[5*i +: 5]] = 1'b1;
            end
        end
        if (rf_we_q) begin
            pending[rf_waddr_q] = 1'b1;
        end
        pending[0] = 1'b0;
    end

    assign rf_we_o      = rf_we_q;
    assign rf_waddr_o   = rf_waddr_q;
    assign rf_wdata_o   = rf_wdata_q;
    assign wb_pending_o = pending;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed scenarios, then constrained-random traffic.
// Reference model: modular search for the winner plus a one-deep write register.
// Requesters hold valid/rd/data until their transfer, as the handshake requires.
module tb_regfile_wb_arbiter;

    localparam int N  = 3;
    localparam int XL = 32;

    logic            clk = 1'b0;
    logic            reset;
    logic            stall;
    logic [N-1:0]    req_valid;
    logic [N*5-1:0]  req_rd;
    logic [N*XL-1:0] req_data;
    logic [N-1:0]    req_ready;
    logic            rf_we;
    logic [4:0]      rf_waddr;
    logic [XL-1:0]   rf_wdata;
    logic [31:0]     wb_pending;

    always #5 clk = ~clk;

    regfile_wb_arbiter #(.NUM_REQ(N), .XLEN(XL)) dut (
        .clk          (clk),
        .reset        (reset),
        .stall_i      (stall),
        .req_valid_i  (req_valid),
        .req_rd_i     (req_rd),
        .req_data_i   (req_data),
        .req_ready_o  (req_ready),
        .rf_we_o      (rf_we),
        .rf_waddr_o   (rf_waddr),
        .rf_wdata_o   (rf_wdata),
        .wb_pending_o (wb_pending)
    );

    int errors = 0;
    int checks = 0;

    // Requester-side stimulus state.
    logic [N-1:0]  tb_v;
    logic [4:0]    tb_rd   [N];
    logic [XL-1:0] tb_data [N];

    // Reference model state.
    int            m_ptr;
    logic          m_we;
    logic [4:0]    m_waddr;
    logic [XL-1:0] m_wdata;
    int            last_g;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input logic [N-1:0] v, input int ptr);
        for (int k = 0; k < N; k++) begin
            if (v[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [31:0] pend_model();
        logic [31:0] p;
        p = '0;
        for (int r = 1; r < 32; r++) begin
            for (int i = 0; i < N; i++) begin
                if (tb_v[i] && int'(tb_rd[i]) == r) p[r] = 1'b1;
            end
            if (m_we && int'(m_waddr) == r) p[r] = 1'b1;
        end
        return p;
    endfunction

    task automatic apply();
        for (int i = 0; i < N; i++) begin
            req_valid[i]          = tb_v[i];
            req_rd[5*i +: 5]      = tb_rd[i];
            req_data[XL*i +: XL]  = tb_data[i];
        end
    endtask

    task automatic chk_out();
        chk("rf_we", 64'(rf_we), 64'(m_we));
        chk("rf_waddr", 64'(rf_waddr), 64'(m_waddr));
        chk("rf_wdata", 64'(rf_wdata), 64'(m_wdata));
    endtask

    // One clock cycle: drive, check comb + registered outputs, advance the model.
    task automatic step(input logic st);
        logic [N-1:0] exp_rdy;
        int g;
        stall = st;
        apply();
        #1;
        g = st ? -1 : pick(tb_v, m_ptr);
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        chk("req_ready", 64'(req_ready), 64'(exp_rdy));
        chk("wb_pending", 64'(wb_pending), 64'(pend_model()));
        chk_out();
        last_g = g;
        @(posedge clk);
        if (g >= 0) begin
            m_ptr   = (g + 1) % N;
            m_we    = (tb_rd[g] != 5'd0);
            m_waddr = tb_rd[g];
            m_wdata = tb_data[g];
        end else begin
            m_we = 1'b0;
        end
        @(negedge clk);
    endtask

    // One reset cycle; an already-presented write still shows during it.
    task automatic do_reset();
        reset = 1'b1;
        stall = 1'b0;
        apply();
        #1;
        chk("ready_in_reset", 64'(req_ready), 64'(0));
        chk_out();
        @(posedge clk);
        m_ptr = 0; m_we = 1'b0; m_waddr = '0; m_wdata = '0;
        @(negedge clk);
        reset = 1'b0;
        tb_v  = '0;
    endtask

    initial begin
        reset = 1'b1;
        stall = 1'b0;
        tb_v  = '0;
        for (int i = 0; i < N; i++) begin
            tb_rd[i]   = '0;
            tb_data[i] = '0;
        end
        apply();
        m_ptr = 0; m_we = 1'b0; m_waddr = '0; m_wdata = '0; last_g = -1;
        @(negedge clk);
        @(negedge clk);
        chk("reset_ready", 64'(req_ready), 64'(0));
        chk("reset_we", 64'(rf_we), 64'(0));
        chk("reset_waddr", 64'(rf_waddr), 64'(0));
        chk("reset_wdata", 64'(rf_wdata), 64'(0));
        reset = 1'b0;

        // Single write to x5, visible one cycle later, gone the cycle after.
        tb_v = 3'b001; tb_rd[0] = 5'd5; tb_data[0] = 32'hDEADBEEF;
        step(1'b0);
        chk("t1_grant", 64'(last_g), 64'(0));
        chk("t1_we", 64'(rf_we), 64'(1));
        chk("t1_waddr", 64'(rf_waddr), 64'(5));
        chk("t1_wdata", 64'(rf_wdata), 64'(32'hDEADBEEF));
        tb_v = '0;
        step(1'b0);
        chk("t1_we_drop", 64'(rf_we), 64'(0));

        // All three valid: strict rotation 0,1,2,... and a continuously busy port.
        do_reset();
        tb_v = 3'b111;
        for (int i = 0; i < N; i++) begin
            tb_rd[i]   = 5'(i + 1);
            tb_data[i] = 32'h100 + 32'(i);
        end
        for (int c = 0; c < 6; c++) begin
            step(1'b0);
            chk("t2_grant", 64'(last_g), 64'(c % 3));
            chk("t2_we", 64'(rf_we), 64'(1));
        end

        // Write to x0: accepted but never reaches the port or the bitmap.
        do_reset();
        tb_v = 3'b010; tb_rd[1] = 5'd0; tb_data[1] = 32'h55;
        step(1'b0);
        chk("t3_grant", 64'(last_g), 64'(1));
        chk("t3_we", 64'(rf_we), 64'(0));
        chk("t3_pending", 64'(wb_pending), 64'(0));
        tb_v = '0;
        step(1'b0);

        // Same destination x7 from requesters 0 and 2: grant order sets write order.
        do_reset();
        tb_v = 3'b101;
        tb_rd[0] = 5'd7; tb_data[0] = 32'h11;
        tb_rd[2] = 5'd7; tb_data[2] = 32'h22;
        step(1'b0);
        chk("t4_first", 64'(rf_wdata), 64'(32'h11));
        chk("t4_pend_a", 64'(wb_pending[7]), 64'(1));
        tb_v = 3'b100;
        step(1'b0);
        chk("t4_second", 64'(rf_wdata), 64'(32'h22));
        chk("t4_pend_b", 64'(wb_pending[7]), 64'(1));
        tb_v = '0;
        step(1'b0);
        chk("t4_pend_clear", 64'(wb_pending), 64'(0));

        // Stall: no grants, pointer frozen, then resume from the saved pointer.
        do_reset();
        tb_v = 3'b001; tb_rd[0] = 5'd3; tb_data[0] = 32'hA0;
        step(1'b0);
        tb_v = 3'b111;
        for (int i = 0; i < N; i++) tb_rd[i] = 5'(10 + i);
        for (int c = 0; c < 3; c++) begin
            step(1'b1);
            chk("t5_no_grant", 64'(last_g), 64'(-1));
            chk("t5_we", 64'(rf_we), 64'(0));
        end
        step(1'b0);
        chk("t5_resume", 64'(last_g), 64'(1));

        // Reset right after a grant: the pending write is dropped, pointer back to 0.
        tb_v = 3'b001;
        step(1'b0);
        chk("t6_grant", 64'(last_g), 64'(0));
        do_reset();
        chk("t6_we", 64'(rf_we), 64'(0));
        tb_v = 3'b111;
        step(1'b0);
        chk("t6_ptr0", 64'(last_g), 64'(0));

        // Random traffic with stalls; small rd range forces collisions and x0 writes.
        do_reset();
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!tb_v[i] && ($urandom % 2 == 0)) begin
                    tb_v[i]    = 1'b1;
                    tb_rd[i]   = 5'($urandom_range(0, 7));
                    tb_data[i] = $urandom;
                end
            end
            step($urandom % 8 == 0);
            if (last_g >= 0) tb_v[last_g] = 1'b0;
        end
        tb_v = '0;
        step(1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
